// File: rtl/id_stage_pipe_if.sv
// Bundle of fetch, writeback, flush and execute-side signals for the decode stage.
// The decode stage connects through the slave modport; fetch/execute drive the master side.
interface id_stage_pipe_if #(
    parameter int DATA_WIDTH = 32
);
    localparam int AW = 5;

    logic                  if_valid_in;
    logic                  if_ready_out;
    logic [31:0]           if_inst_in;
    logic [DATA_WIDTH-1:0] if_pc_in;

    logic                  wb_en_in;
    logic [AW-1:0]         wb_rd_in;
    logic [DATA_WIDTH-1:0] wb_data_in;

    logic                  flush_in;

    logic                  ex_valid_out;
    logic                  ex_ready_in;
    logic [DATA_WIDTH-1:0] ex_pc_out;
    logic [DATA_WIDTH-1:0] ex_opr_a_out;
    logic [DATA_WIDTH-1:0] ex_opr_b_out;
    logic [DATA_WIDTH-1:0] ex_imm_out;
    logic [6:0]            ex_opcode_out;
    logic [2:0]            ex_funct3_out;
    logic [6:0]            ex_funct7_out;
    logic [AW-1:0]         ex_rd_out;

    modport slave (
        input  if_valid_in, if_inst_in, if_pc_in,
        input  wb_en_in, wb_rd_in, wb_data_in,
        input  flush_in, ex_ready_in,
        output if_ready_out, ex_valid_out, ex_pc_out, ex_opr_a_out, ex_opr_b_out,
        output ex_imm_out, ex_opcode_out, ex_funct3_out, ex_funct7_out, ex_rd_out
    );

    modport master (
        output if_valid_in, if_inst_in, if_pc_in,
        output wb_en_in, wb_rd_in, wb_data_in,
        output flush_in, ex_ready_in,
        input  if_ready_out, ex_valid_out, ex_pc_out, ex_opr_a_out, ex_opr_b_out,
        input  ex_imm_out, ex_opcode_out, ex_funct3_out, ex_funct7_out, ex_rd_out
    );
endinterface

// File: rtl/id_stage_pipe.sv
// RV32 decode stage: register file, immediate generation, load-use stall and one output register.
// Optional macro ID_STAGE_PIPE_WB_BYPASS_EN forwards same-cycle writeback data into the operands.
module id_stage_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32
) (
    input  logic           clk,
    input  logic           arst_n,
    id_stage_pipe_if.slave bus
);
    localparam int AW = 5;

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];

    logic [31:0]           inst;
    logic [6:0]            opcode;
    logic [AW-1:0]         rs1;
    logic [AW-1:0]         rs2;
    logic                  wb_write;
    logic [DATA_WIDTH-1:0] rf_a;
    logic [DATA_WIDTH-1:0] rf_b;
    logic [DATA_WIDTH-1:0] opr_a;
    logic [DATA_WIDTH-1:0] opr_b;
    logic [31:0]           imm32;
    logic [DATA_WIDTH-1:0] imm;
    logic                  hazard;
    logic                  ready;
    logic                  accept;

    logic                  ex_valid;
    logic [DATA_WIDTH-1:0] ex_pc;
    logic [DATA_WIDTH-1:0] ex_opr_a;
    logic [DATA_WIDTH-1:0] ex_opr_b;
    logic [DATA_WIDTH-1:0] ex_imm;
    logic [6:0]            ex_opcode;
    logic [2:0]            ex_funct3;
    logic [6:0]            ex_funct7;
    logic [AW-1:0]         ex_rd;

    assign inst   = bus.if_inst_in;
    assign opcode = inst[6:0];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];

    assign wb_write = bus.wb_en_in && (bus.wb_rd_in != '0) && (int'(bus.wb_rd_in) < REG_COUNT);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else if (wb_write) begin
            regs[bus.wb_rd_in] <= bus.wb_data_in;
        end
    end

    // x0 and indices beyond the implemented register count read as zero.
    always_comb begin
        rf_a = '0;
        rf_b = '0;
        if (rs1 != '0 && int'(rs1) < REG_COUNT) rf_a = regs[rs1];
        if (rs2 != '0 && int'(rs2) < REG_COUNT) rf_b = regs[rs2];
    end

`ifdef ID_STAGE_PIPE_WB_BYPASS_EN
    assign opr_a = (wb_write && bus.wb_rd_in == rs1) ? bus.wb_data_in : rf_a;
    assign opr_b = (wb_write && bus.wb_rd_in == rs2) ? bus.wb_data_in : rf_b;
`else
    assign opr_a = rf_a;
    assign opr_b = rf_b;
`endif

    // Every format places the sign bit at inst[31], so imm32[31] is always the extension bit.
    always_comb begin
        imm32 = '0;
        case (opcode)
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011:
                imm32 = {{20{inst[31]}}, inst[31:20]};
            7'b0100011:
                imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            7'b1100011:
                imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                imm32 = {inst[31:12], 12'b0};
            7'b1101111:
                imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    assign imm = DATA_WIDTH'($signed(imm32));

    assign hazard = ex_valid && (ex_opcode == 7'b0000011) && (ex_rd != '0) &&
                    ((rs1 == ex_rd) || (rs2 == ex_rd));
    assign ready  = bus.flush_in || ((!ex_valid || bus.ex_ready_in) && !hazard);
    assign accept = bus.if_valid_in && ready && !bus.flush_in;

    // Flush beats accept; a drain or load-use bubble only clears valid, payload keeps its value.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ex_valid  <= 1'b0;
            ex_pc     <= '0;
            ex_opr_a  <= '0;
            ex_opr_b  <= '0;
            ex_imm    <= '0;
            ex_opcode <= '0;
            ex_funct3 <= '0;
            ex_funct7 <= '0;
            ex_rd     <= '0;
        end else if (bus.flush_in) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid  <= 1'b1;
            ex_pc     <= bus.if_pc_in;
            ex_opr_a  <= opr_a;
            ex_opr_b  <= opr_b;
            ex_imm    <= imm;
            ex_opcode <= opcode;
            ex_funct3 <= inst[14:12];
            ex_funct7 <= inst[31:25];
            ex_rd     <= inst[11:7];
        end else if (bus.ex_ready_in) begin
            ex_valid <= 1'b0;
        end
    end

    assign bus.if_ready_out  = ready;
    assign bus.ex_valid_out  = ex_valid;
    assign bus.ex_pc_out     = ex_pc;
    assign bus.ex_opr_a_out  = ex_opr_a;
    assign bus.ex_opr_b_out  = ex_opr_b;
    assign bus.ex_imm_out    = ex_imm;
    assign bus.ex_opcode_out = ex_opcode;
    assign bus.ex_funct3_out = ex_funct3;
    assign bus.ex_funct7_out = ex_funct7;
    assign bus.ex_rd_out     = ex_rd;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: directed instructions push expected bundles,
// a negedge monitor pops and compares every transfer toward execute.
module tb_id_stage_pipe;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
    } bundle_t;

`ifdef ID_STAGE_PIPE_WB_BYPASS_EN
    localparam logic [31:0] BYP_X5 = 32'h0000_1234;
`else
    localparam logic [31:0] BYP_X5 = 32'h0000_0000;
`endif

    logic clk;
    logic arst_n;
    int   checks;
    int   errors;
    bundle_t expq[$];

    id_stage_pipe_if #(.DATA_WIDTH(32)) bus ();

    id_stage_pipe #(.DATA_WIDTH(32), .REG_COUNT(32)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                                 input logic rdy, input logic fl, input logic we,
                                 input logic [4:0] rd, input logic [31:0] wd);
        bus.if_valid_in = v;
        bus.if_inst_in  = inst;
        bus.if_pc_in    = pc;
        bus.ex_ready_in = rdy;
        bus.flush_in    = fl;
        bus.wb_en_in    = we;
        bus.wb_rd_in    = rd;
        bus.wb_data_in  = wd;
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(1'b0, 32'h0000_0013, 32'h0, rdy, 1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic expectBundle(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] imm, input logic [31:0] inst);
        bundle_t e;
        e.pc  = pc;
        e.a   = a;
        e.b   = b;
        e.imm = imm;
        e.op  = inst[6:0];
        e.f3  = inst[14:12];
        e.f7  = inst[31:25];
        e.rd  = inst[11:7];
        expq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every handshake toward execute must match the oldest outstanding expectation.
    initial begin : monitor
        bundle_t act;
        bundle_t e;
        forever begin
            @(negedge clk);
            if (arst_n && bus.ex_valid_out && bus.ex_ready_in) begin
                act = {bus.ex_pc_out, bus.ex_opr_a_out, bus.ex_opr_b_out, bus.ex_imm_out,
                       bus.ex_opcode_out, bus.ex_funct3_out, bus.ex_funct7_out, bus.ex_rd_out};
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_bundle actual=%h expected=none", act);
                end else begin
                    e = expq.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("[TB] FAIL bundle pc=%h actual=%h expected=%h", e.pc, act, e);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        checks = 0;
        errors = 0;
        arst_n = 1'b0;
        idle(1'b1);
        #3;
        checkOutput("reset_ready", {31'd0, bus.if_ready_out}, 32'd1);
        checkOutput("reset_valid", {31'd0, bus.ex_valid_out}, 32'd0);
        checkOutput("reset_pc", bus.ex_pc_out, 32'd0);
        checkOutput("reset_imm", bus.ex_imm_out, 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        tick();

        // addi x1,x0,-5
        applyStimulus(1'b1, 32'hFFB0_0093, 32'h100, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        expectBundle(32'h100, 32'h0, 32'h0, 32'hFFFF_FFFB, 32'hFFB0_0093);
        @(negedge clk);
        checkOutput("addi_ready", {31'd0, bus.if_ready_out}, 32'd1);
        tick();
        idle(1'b1);
        @(negedge clk);
        checkOutput("addi_valid", {31'd0, bus.ex_valid_out}, 32'd1);
        checkOutput("addi_imm", bus.ex_imm_out, 32'hFFFF_FFFB);
        checkOutput("addi_rd", {27'd0, bus.ex_rd_out}, 32'd1);
        tick();
        @(negedge clk);
        checkOutput("drain_valid", {31'd0, bus.ex_valid_out}, 32'd0);

        // add x6,x5,x5 with same-cycle writeback of x5, then add x7,x5,x5 reads the stored value
        applyStimulus(1'b1, 32'h0052_8333, 32'h104, 1'b1, 1'b0, 1'b1, 5'd5, 32'h1234);
        expectBundle(32'h104, BYP_X5, BYP_X5, 32'h0, 32'h0052_8333);
        tick();
        applyStimulus(1'b1, 32'h0052_83B3, 32'h108, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        expectBundle(32'h108, 32'h1234, 32'h1234, 32'h0, 32'h0052_83B3);
        tick();
        idle(1'b1);
        tick();

        // lw x2,0(x1) then add x3,x2,x2: one bubble; x2 written back during the bubble
        applyStimulus(1'b1, 32'h0000_A103, 32'h10C, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        expectBundle(32'h10C, 32'h0, 32'h0, 32'h0, 32'h0000_A103);
        tick();
        applyStimulus(1'b1, 32'h0021_01B3, 32'h110, 1'b1, 1'b0, 1'b1, 5'd2, 32'hCAFE);
        @(negedge clk);
        checkOutput("hazard_ready", {31'd0, bus.if_ready_out}, 32'd0);
        checkOutput("hazard_valid", {31'd0, bus.ex_valid_out}, 32'd1);
        tick();
        applyStimulus(1'b1, 32'h0021_01B3, 32'h110, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        expectBundle(32'h110, 32'hCAFE, 32'hCAFE, 32'h0, 32'h0021_01B3);
        @(negedge clk);
        checkOutput("bubble_valid", {31'd0, bus.ex_valid_out}, 32'd0);
        checkOutput("bubble_ready", {31'd0, bus.if_ready_out}, 32'd1);
        tick();
        idle(1'b1);
        @(negedge clk);
        checkOutput("after_bubble_valid", {31'd0, bus.ex_valid_out}, 32'd1);
        tick();

        // addi x4,x0,100 held three cycles while sw x5,8(x0) waits
        applyStimulus(1'b1, 32'h0640_0213, 32'h114, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        expectBundle(32'h114, 32'h0, 32'h0, 32'd100, 32'h0640_0213);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h0050_2423, 32'h118, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
            @(negedge clk);
            checkOutput("stall_ready", {31'd0, bus.if_ready_out}, 32'd0);
            checkOutput("stall_valid", {31'd0, bus.ex_valid_out}, 32'd1);
            checkOutput("stall_pc", bus.ex_pc_out, 32'h114);
            checkOutput("stall_imm", bus.ex_imm_out, 32'd100);
            tick();
        end
        applyStimulus(1'b1, 32'h0050_2423, 32'h118, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        expectBundle(32'h118, 32'h0, 32'h1234, 32'd8, 32'h0050_2423);
        @(negedge clk);
        checkOutput("unstall_ready", {31'd0, bus.if_ready_out}, 32'd1);
        tick();
        idle(1'b1);
        tick();

        // flush while a load-use hazard is pending; the held lw and offered add are dropped
        applyStimulus(1'b1, 32'h0000_A103, 32'h11C, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        applyStimulus(1'b1, 32'h0021_01B3, 32'h120, 1'b0, 1'b1, 1'b1, 5'd0, 32'hDEAD);
        @(negedge clk);
        checkOutput("flush_ready", {31'd0, bus.if_ready_out}, 32'd1);
        tick();
        idle(1'b1);
        @(negedge clk);
        checkOutput("flush_valid", {31'd0, bus.ex_valid_out}, 32'd0);
        tick();
        // add x9,x0,x0 while another x0 write is attempted
        applyStimulus(1'b1, 32'h0000_04B3, 32'h124, 1'b1, 1'b0, 1'b1, 5'd0, 32'hDEAD);
        expectBundle(32'h124, 32'h0, 32'h0, 32'h0, 32'h0000_04B3);
        tick();

        // lui, jal, beq back-to-back for U/J/B immediates
        applyStimulus(1'b1, 32'hABCD_E537, 32'h128, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        expectBundle(32'h128, 32'h0, 32'h0, 32'hABCD_E000, 32'hABCD_E537);
        tick();
        applyStimulus(1'b1, 32'hFFDF_F0EF, 32'h12C, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        expectBundle(32'h12C, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'hFFDF_F0EF);
        tick();
        applyStimulus(1'b1, 32'hFE00_0CE3, 32'h130, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        expectBundle(32'h130, 32'h0, 32'h0, 32'hFFFF_FFF8, 32'hFE00_0CE3);
        tick();
        idle(1'b1);
        tick();

        // reset while a bundle is stalled: it vanishes and the register file clears
        applyStimulus(1'b1, 32'h0640_0213, 32'h200, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        idle(1'b0);
        #1;
        arst_n = 1'b0;
        #1;
        checkOutput("midreset_valid", {31'd0, bus.ex_valid_out}, 32'd0);
        checkOutput("midreset_ready", {31'd0, bus.if_ready_out}, 32'd1);
        checkOutput("midreset_pc", bus.ex_pc_out, 32'd0);
        checkOutput("midreset_imm", bus.ex_imm_out, 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        tick();
        applyStimulus(1'b1, 32'h0052_8333, 32'h204, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        expectBundle(32'h204, 32'h0, 32'h0, 32'h0, 32'h0052_8333);
        tick();
        idle(1'b1);
        tick();
        tick();

        checkOutput("scoreboard_empty", expq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
